ftsr_dup_queue: RTL and testbench

Fetch-side buffer directly downstream of the instruction scanner in the FTSR frontend. It accepts scanned 32-bit instructions together with their redundancy flag and buffers them in a small FIFO. When emitting, it issues every redundancy-eligible instruction twice, first as a primary copy and then as a shadow copy, so the backend can execute and compare both. Non-eligible instructions pass through once.

---
 rtl/ftsr_dup_queue.sv | 148 ++++++++++++++
 tb/tb_ftsr_dup_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ftsr_dup_queue.sv
`default_nettype none
// ============================================================================
// Module  : ftsr_dup_queue
// Brief   : Fetch-side instruction FIFO that issues redundancy-eligible entries
//           twice (primary, then shadow). Duplication is enabled by defining
//           the macro FTSR_DUP_QUEUE_EN; otherwise it is a plain FIFO.
// Revision: 1.0 - initial release
// ============================================================================

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32};
endpackage

module ftsr_dup_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned            DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [31:0]             instr_i,
    input  logic [CVA6Cfg.VLEN-1:0] addr_i,
    input  logic                    redundant_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [31:0]             instr_o,
    output logic [CVA6Cfg.VLEN-1:0] addr_o,
    output logic                    redundant_o,
    output logic                    copy_o
);

    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]             instr_q [DEPTH];
    logic [CVA6Cfg.VLEN-1:0] addr_q  [DEPTH];
    logic [DEPTH-1:0]        red_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic handshake;

    // Full is judged on the current count only: no pop-then-push bypass.
    assign ready_o     = (count_q != FULL_COUNT);
    assign valid_o     = (count_q != '0);
    assign instr_o     = instr_q[rd_ptr_q];
    assign addr_o      = addr_q[rd_ptr_q];
    assign redundant_o = red_q[rd_ptr_q];

    assign push      = valid_i & ready_o & ~flush_i;
    assign handshake = valid_o & ready_i;

`ifdef FTSR_DUP_QUEUE_EN
    typedef enum logic [0:0] {
        PRIMARY = 1'b0,
        SHADOW  = 1'b1
    } state_e;

    state_e shadow_q, shadow_d;

    // A redundant head is held for a second (shadow) handshake before popping.
    always_comb begin
        shadow_d = shadow_q;
        pop      = 1'b0;
        if (flush_i) begin
            shadow_d = PRIMARY;
        end else if (handshake) begin
            if ((shadow_q == PRIMARY) && redundant_o) begin
                shadow_d = SHADOW;
            end else begin
                pop      = 1'b1;
                shadow_d = PRIMARY;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= PRIMARY;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign copy_o = (shadow_q == SHADOW);
`else
    assign pop    = handshake & ~flush_i;
    assign copy_o = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr_q] <= instr_i;
            addr_q[wr_ptr_q]  <= addr_i;
            red_q[wr_ptr_q]   <= redundant_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ftsr_dup_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_ftsr_dup_queue
// Brief   : Directed and randomized checks of ftsr_dup_queue against a
//           queue-based behavioural model.
// Revision: 1.0 - initial release
// ============================================================================

module tb_ftsr_dup_queue;

    localparam int unsigned DEPTH = 4;

`ifdef FTSR_DUP_QUEUE_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        red;
    } entry_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] addr_i = '0;
    logic        redundant_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        redundant_o;
    logic        copy_o;

    entry_t model_q[$];
    bit     model_shadow = 1'b0;
    int     tests = 0;
    int     fails = 0;

    ftsr_dup_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .instr_i    (instr_i),
        .addr_i     (addr_i),
        .redundant_i(redundant_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .instr_o    (instr_o),
        .addr_o     (addr_o),
        .redundant_o(redundant_o),
        .copy_o     (copy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_o", valid_o, model_q.size() != 0);
        chk("ready_o", ready_o, model_q.size() != DEPTH);
        chk("copy_o", copy_o, model_shadow);
        if (model_q.size() != 0) begin
            chk("instr_o", instr_o, model_q[0].instr);
            chk("addr_o", addr_o, model_q[0].addr);
            chk("redundant_o", redundant_o, model_q[0].red);
        end
    endtask

    // Called at posedge+1; drives inputs, checks at negedge, advances the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic r, input logic rdy, input logic fl);
        bit     acc;
        bit     hs;
        entry_t e;
        valid_i     = v;
        instr_i     = ins;
        addr_i      = a;
        redundant_i = r;
        ready_i     = rdy;
        flush_i     = fl;
        @(negedge clk_i);
        check_outputs();
        acc = v && (model_q.size() != DEPTH) && !fl;
        hs  = (model_q.size() != 0) && rdy;
        if (fl) begin
            model_q.delete();
            model_shadow = 1'b0;
        end else begin
            if (hs) begin
                if (DUP_EN && model_q[0].red && !model_shadow) begin
                    model_shadow = 1'b1;
                end else begin
                    void'(model_q.pop_front());
                    model_shadow = 1'b0;
                end
            end
            if (acc) begin
                e.instr = ins;
                e.addr  = a;
                e.red   = r;
                model_q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        // Asynchronous reset assertion, checked before any clock edge.
        #1 rst_i = 1'b1;
        #2;
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b1);
        chk("rst_copy_o", copy_o, 1'b0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(1'b1, 2);

        // Redundant duplication.
        step(1'b1, 32'h00B50533, 32'h80000000, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Pass-through, then 8 back-to-back.
        step(1'b1, 32'h0000006F, 32'h80000004, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h0000006F, 32'h80001000 + 4 * i, 1'b0, 1'b1, 1'b0);
        end
        idle(1'b1, 2);

        // Fill under backpressure, reject 5th, drain, then wrap.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 32'h1000 + 16 * k + i, 32'h2000 + 4 * i, i[0], 1'b0, 1'b0);
            end
            idle(1'b1, 10);
        end

        // Stall in shadow.
        step(1'b1, 32'h00B50533, 32'h80000100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 3);

        // Flush priority with three entries and a pending shadow.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00C58633 + i, 32'h80000200 + 4 * i, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hDEADBEEF, 32'h80000300, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, $urandom % 2,
                 ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        // Asynchronous reset with a non-empty queue.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h3000 + i, 32'h4000 + i, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        #2;
        model_q.delete();
        model_shadow = 1'b0;
        check_outputs();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(1'b1, 2);
        step(1'b1, 32'h00B50533, 32'h80000400, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
